km_exp_ctrl: RTL
================

KM_EXP_CTRL -- requirements
Module: km_exp_ctrl

Interface
REQ-001 Parameter W, default 32, operand/result width in bits.
REQ-002 Parameter EW, default 32, exponent width in bits.
REQ-003 Parameter Q, default 32'd4294967291, modulus; odd, 2^(W-1) < Q < 2^W.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  controller idle, request accepted this cycle if in_valid.
REQ-008 base  input  W  base operand, any value in [0, 2^W).
REQ-009 exp  input  EW  exponent, unsigned.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_data  output  W  base^exp mod Q, in [0, Q).
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Computes base^exp mod Q by left-to-right binary square-and-multiply, one modular product per cycle.
REQ-015 States: IDLE, SQR, MUL, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: on in_valid, capture base_r = (base >= Q) ? base-Q : base, exp_r = exp, acc = 1, cnt = EW-1; go to SQR.
REQ-017 SQR: acc <= acc*acc mod Q; if exp_r[cnt]=1 go to MUL; else if cnt=0 go to DONE; else cnt <= cnt-1, stay in SQR.
REQ-018 MUL: acc <= acc*base_r mod Q; if cnt=0 go to DONE; else cnt <= cnt-1, go to SQR.
REQ-019 DONE: out_data = acc, held stable while out_ready=0; on out_ready go to IDLE.
REQ-020 Latency: out_valid rises exactly EW + popcount(exp) cycles after the accept edge; 32 min, 64 max for the defaults.
REQ-021 No new request is accepted before the result handshake; in_ready rises the cycle after the out_valid & out_ready edge.
REQ-022 exp=0 yields 1 for every base, including base=0.
REQ-023 Multiplier operands are always in [0, Q); the multiplier output is taken as fully reduced and registered directly into acc.
REQ-024 Inputs base/exp are sampled only on the accept edge; later changes have no effect.

Reset
REQ-025 rst_n low: state=IDLE, acc=1, cnt=0, base_r=0, exp_r=0 immediately, independent of clk.
REQ-026 Reset outputs: in_ready=1, out_valid=0, busy=0, out_data=1.
REQ-027 Reset mid-operation abandons the computation; no out_valid is produced for it.

Structure
REQ-028 Package km_pkg holds W, EW, Q defaults and the state encoding constants.
REQ-029 Exactly one instance of the existing combinational multiplier km_rtl (ports a, b, p), shared between SQR and MUL through an operand mux (b = acc in SQR, b = base_r in MUL; a = acc).
REQ-030 Counter width is clog2(EW); no other arithmetic instances.

Verification
REQ-031 base=13333, exp=2 -> out_data=177768889 after 33 cycles.
REQ-032 base=2, exp=32 -> out_data=5; base=0, exp=0 -> out_data=1 after 32 cycles.
REQ-033 base=32'hFFFFFFFF, exp=1 -> out_data=4 (input reduction); base=3, exp=4294967290 -> out_data=1 (Fermat).
REQ-034 exp=32'hFFFFFFFF -> out_valid 64 cycles after accept; out_ready held 0 for 5 cycles -> out_data stable, in_ready=0, busy=1.
REQ-035 rst_n pulsed low 10 cycles after accept -> outputs at reset values immediately, no out_valid; next request completes correctly.

Source files
------------

// File: rtl/km_pkg.sv
// Shared defaults and state encoding for the modular exponentiation controller.
package km_pkg;
   localparam int          KM_W_DEF  = 32;
   localparam int          KM_EW_DEF = 32;
   localparam logic [31:0] KM_Q_DEF  = 32'd4294967291;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SQR  = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } km_state_e;
endpackage

// File: rtl/km_rtl.sv
// Combinational modular multiplier: p = a*b mod Q, operands assumed in [0, Q).
module km_rtl #(
   parameter int         W = 32,
   parameter logic [W-1:0] Q = 32'd4294967291
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);
   localparam logic [2*W-1:0] QW = {{W{1'b0}}, Q};

   logic [2*W-1:0] prod;
   logic [2*W-1:0] rem;

   // Full-width product followed by a single reduction.
   always_comb begin
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      rem  = prod % QW;
      p    = rem[W-1:0];
   end
endmodule

// File: rtl/km_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod Q,
// one modular product per cycle through a single shared multiplier.
module km_exp_ctrl
   import km_pkg::*;
#(
   parameter int           W  = KM_W_DEF,
   parameter int           EW = KM_EW_DEF,
   parameter logic [W-1:0] Q  = KM_Q_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  base,
   input  logic [EW-1:0] exp,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          busy
);
   localparam int CW = (EW > 1) ? $clog2(EW) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(EW - 1);
   localparam logic [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1};

   km_state_e     state_q;
   logic [W-1:0]  acc_q;
   logic [W-1:0]  base_r_q;
   logic [EW-1:0] exp_r_q;
   logic [CW-1:0] cnt_q;

   logic [W-1:0]  mul_b;
   logic [W-1:0]  mul_p;
   logic [W-1:0]  base_red_d;

   // Square uses acc as both operands; multiply swaps in the reduced base.
   always_comb begin
      mul_b      = (state_q == ST_MUL) ? base_r_q : acc_q;
      base_red_d = (base >= Q) ? (base - Q) : base;
   end

   km_rtl #(.W(W), .Q(Q)) u_mul (
      .a (acc_q),
      .b (mul_b),
      .p (mul_p)
   );

   // Controller FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= ONE;
         cnt_q    <= '0;
         base_r_q <= '0;
         exp_r_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  base_r_q <= base_red_d;
                  exp_r_q  <= exp;
                  acc_q    <= ONE;
                  cnt_q    <= CNT_TOP;
                  state_q  <= ST_SQR;
               end
            end
            ST_SQR: begin
               acc_q <= mul_p;
               if (exp_r_q[cnt_q]) begin
                  state_q <= ST_MUL;
               end else if (cnt_q == '0) begin
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_MUL: begin
               acc_q <= mul_p;
               if (cnt_q == '0) begin
                  state_q <= ST_DONE;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
                  state_q <= ST_SQR;
               end
            end
            ST_DONE: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Status outputs decode straight from the state register.
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      out_data  = acc_q;
   end
endmodule
